// File: rtl/id_ex_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs for the ID/EX stage.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic                     id_valid_i;
  logic [REG_AW-1:0]        id_rs_addr_i;
  logic [REG_AW-1:0]        id_rt_addr_i;
  logic [REG_AW-1:0]        id_rd_addr_i;
  logic signed [DATA_W-1:0] id_rs_data_i;
  logic signed [DATA_W-1:0] id_rt_data_i;
  logic signed [DATA_W-1:0] id_imm_i;
  logic [2:0]               id_alu_ctrl_i;
  logic                     id_alu_src_i;
  logic                     id_reg_dst_i;
  logic                     id_reg_write_i;
  logic                     id_mem_read_i;
  logic                     id_mem_write_i;
  logic                     id_mem_to_reg_i;
  logic                     stall_i;
  logic                     flush_i;
  logic                     exmem_reg_write_i;
  logic [REG_AW-1:0]        exmem_rd_i;
  logic signed [DATA_W-1:0] exmem_data_i;
  logic                     memwb_reg_write_i;
  logic [REG_AW-1:0]        memwb_rd_i;
  logic signed [DATA_W-1:0] memwb_data_i;
  logic signed [DATA_W-1:0] alu_data1_o;
  logic signed [DATA_W-1:0] alu_data2_o;
  logic [2:0]               alu_ctrl_o;
  logic signed [DATA_W-1:0] ex_store_data_o;
  logic [REG_AW-1:0]        ex_wr_addr_o;
  logic                     ex_valid_o;
  logic                     ex_reg_write_o;
  logic                     ex_mem_read_o;
  logic                     ex_mem_write_o;
  logic                     ex_mem_to_reg_o;
  logic                     load_use_o;

  modport master (
    output id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_alu_ctrl_i,
           id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i,
           id_mem_write_i, id_mem_to_reg_i, stall_i, flush_i,
           exmem_reg_write_i, exmem_rd_i, exmem_data_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    input  alu_data1_o, alu_data2_o, alu_ctrl_o, ex_store_data_o,
           ex_wr_addr_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o,
           ex_mem_write_o, ex_mem_to_reg_o, load_use_o
  );

  modport slave (
    input  id_valid_i, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
           id_rs_data_i, id_rt_data_i, id_imm_i, id_alu_ctrl_i,
           id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i,
           id_mem_write_i, id_mem_to_reg_i, stall_i, flush_i,
           exmem_reg_write_i, exmem_rd_i, exmem_data_i,
           memwb_reg_write_i, memwb_rd_i, memwb_data_i,
    output alu_data1_o, alu_data2_o, alu_ctrl_o, ex_store_data_o,
           ex_wr_addr_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o,
           ex_mem_write_o, ex_mem_to_reg_o, load_use_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic     clk_i,
  input logic     rst_i,
  id_ex_if.slave  bus
);

  logic                     vld_p0;
  logic [REG_AW-1:0]        rs_addr_p0;
  logic [REG_AW-1:0]        rt_addr_p0;
  logic signed [DATA_W-1:0] rs_data_p0;
  logic signed [DATA_W-1:0] rt_data_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic [2:0]               alu_ctrl_p0;
  logic                     alu_src_p0;
  logic [REG_AW-1:0]        wr_addr_p0;
  logic                     reg_write_p0;
  logic                     mem_read_p0;
  logic                     mem_write_p0;
  logic                     mem_to_reg_p0;

  logic                     load_use;
  logic signed [DATA_W-1:0] rs_fwd;
  logic signed [DATA_W-1:0] rt_fwd;

  // Youngest producer wins; register 0 is hardwired and never forwarded.
  function automatic logic signed [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0]        src_addr,
    input logic signed [DATA_W-1:0] src_data,
    input logic                     ex_we,
    input logic [REG_AW-1:0]        ex_rd,
    input logic signed [DATA_W-1:0] ex_data,
    input logic                     wb_we,
    input logic [REG_AW-1:0]        wb_rd,
    input logic signed [DATA_W-1:0] wb_data
  );
    logic signed [DATA_W-1:0] sel;
    sel = src_data;
    if (ex_we && (ex_rd != '0) && (ex_rd == src_addr))
      sel = ex_data;
    else if (wb_we && (wb_rd != '0) && (wb_rd == src_addr))
      sel = wb_data;
    return sel;
  endfunction

  assign load_use = vld_p0 && mem_read_p0 && (wr_addr_p0 != '0) && bus.id_valid_i &&
                    ((wr_addr_p0 == bus.id_rs_addr_i) || (wr_addr_p0 == bus.id_rt_addr_i));

  // ID -> EX boundary
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      vld_p0        <= 1'b0;
      rs_addr_p0    <= '0;
      rt_addr_p0    <= '0;
      rs_data_p0    <= '0;
      rt_data_p0    <= '0;
      imm_p0        <= '0;
      alu_ctrl_p0   <= 3'b000;
      alu_src_p0    <= 1'b0;
      wr_addr_p0    <= '0;
      reg_write_p0  <= 1'b0;
      mem_read_p0   <= 1'b0;
      mem_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
    end else if (!bus.stall_i) begin
      if (load_use || !bus.id_valid_i) begin
        vld_p0        <= 1'b0;
        rs_addr_p0    <= '0;
        rt_addr_p0    <= '0;
        rs_data_p0    <= '0;
        rt_data_p0    <= '0;
        imm_p0        <= '0;
        alu_ctrl_p0   <= 3'b000;
        alu_src_p0    <= 1'b0;
        wr_addr_p0    <= '0;
        reg_write_p0  <= 1'b0;
        mem_read_p0   <= 1'b0;
        mem_write_p0  <= 1'b0;
        mem_to_reg_p0 <= 1'b0;
      end else begin
        vld_p0        <= 1'b1;
        rs_addr_p0    <= bus.id_rs_addr_i;
        rt_addr_p0    <= bus.id_rt_addr_i;
        rs_data_p0    <= bus.id_rs_data_i;
        rt_data_p0    <= bus.id_rt_data_i;
        imm_p0        <= bus.id_imm_i;
        alu_ctrl_p0   <= bus.id_alu_ctrl_i;
        alu_src_p0    <= bus.id_alu_src_i;
        wr_addr_p0    <= bus.id_reg_dst_i ? bus.id_rd_addr_i : bus.id_rt_addr_i;
        reg_write_p0  <= bus.id_reg_write_i;
        mem_read_p0   <= bus.id_mem_read_i;
        mem_write_p0  <= bus.id_mem_write_i;
        mem_to_reg_p0 <= bus.id_mem_to_reg_i;
      end
    end
  end

  // EX operand selection (combinational from stored slot and forwarding sources)
  always_comb begin
    rs_fwd = fwd_sel(rs_addr_p0, rs_data_p0,
                     bus.exmem_reg_write_i, bus.exmem_rd_i, bus.exmem_data_i,
                     bus.memwb_reg_write_i, bus.memwb_rd_i, bus.memwb_data_i);
    rt_fwd = fwd_sel(rt_addr_p0, rt_data_p0,
                     bus.exmem_reg_write_i, bus.exmem_rd_i, bus.exmem_data_i,
                     bus.memwb_reg_write_i, bus.memwb_rd_i, bus.memwb_data_i);
  end

  assign bus.alu_data1_o     = rs_fwd;
  assign bus.alu_data2_o     = alu_src_p0 ? imm_p0 : rt_fwd;
  assign bus.ex_store_data_o = rt_fwd;
  assign bus.alu_ctrl_o      = alu_ctrl_p0;
  assign bus.ex_wr_addr_o    = wr_addr_p0;
  assign bus.ex_valid_o      = vld_p0;
  assign bus.ex_reg_write_o  = reg_write_p0;
  assign bus.ex_mem_read_o   = mem_read_p0;
  assign bus.ex_mem_write_o  = mem_write_p0;
  assign bus.ex_mem_to_reg_o = mem_to_reg_p0;
  assign bus.load_use_o      = load_use;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU in the 5-stage pipeline. Captures decoded operands and control from ID each cycle, resolves EX/MEM and MEM/WB data hazards, and drives the ALU's two 32-bit operands and 3-bit control code. Detects load-use hazards and inserts the bubble itself. Also carries EX-stage control and write-register address downstream.

## Interface
- DATA_W, 32, datapath width (ALU operand width)
- REG_AW, 5, register-file address width

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs_addr_i / id_rt_addr_i / id_rd_addr_i  in  REG_AW  source and destination register numbers
- id_rs_data_i / id_rt_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_alu_ctrl_i  in  3  ALU op: 000 add, 010 sub, 100 and, 101 or, 111 mul
- id_alu_src_i  in  1  1 = operand 2 is the immediate
- id_reg_dst_i  in  1  1 = write rd, 0 = write rt
- id_reg_write_i / id_mem_read_i / id_mem_write_i / id_mem_to_reg_i  in  1 each  control bits
- stall_i  in  1  downstream hold; EX contents frozen
- flush_i  in  1  kill the instruction entering EX
- exmem_reg_write_i  in  1, exmem_rd_i  in  REG_AW, exmem_data_i  in  DATA_W  EX/MEM forwarding source
- memwb_reg_write_i  in  1, memwb_rd_i  in  REG_AW, memwb_data_i  in  DATA_W  MEM/WB forwarding source
- alu_data1_o / alu_data2_o  out  DATA_W  ALU operands
- alu_ctrl_o  out  3  ALU control code
- ex_store_data_o  out  DATA_W  forwarded rt value, for stores
- ex_wr_addr_o  out  REG_AW  selected destination register
- ex_valid_o / ex_reg_write_o / ex_mem_read_o / ex_mem_write_o / ex_mem_to_reg_o  out  1 each  registered EX control
- load_use_o  out  1  load-use hazard; IF/ID must hold this cycle

## Operation
- State: one EX slot holding valid, rs/rt addr, rs/rt data, imm, alu_ctrl, alu_src, wr_addr, and the four control bits.
- wr_addr is computed at capture: id_reg_dst_i ? id_rd_addr_i : id_rt_addr_i.
- Update priority at each edge: rst_i > flush_i > stall_i > load_use_o > normal capture.
  - rst_i or flush_i: load a bubble. A bubble has valid and all control bits 0, data 0, and alu_ctrl 000.
  - stall_i: hold all state. This applies even while load_use_o is asserted.
  - load_use_o: load a bubble.
  - normal: capture id_* inputs. If id_valid_i=0, load a bubble.
- Forwarding is evaluated separately for rs and for rt.
  - EX/MEM is used when exmem_reg_write_i=1, exmem_rd_i≠0, and exmem_rd_i equals the stored address.
  - Otherwise MEM/WB is used under the same three conditions, with memwb_rd_i.
  - Otherwise the stored register data is used.
  - EX/MEM wins when both sources match.
  - Register 0 is never forwarded.
- alu_data1_o = forwarded rs.
- alu_data2_o = stored imm if alu_src=1, else forwarded rt.
- ex_store_data_o is always forwarded rt.
- alu_ctrl_o = stored alu_ctrl.
- load_use_o = ex_valid & ex_mem_read & wr_addr≠0 & id_valid_i & (wr_addr==id_rs_addr_i | wr_addr==id_rt_addr_i).

## Timing
- Reset values: every registered output is 0.
  - After reset, alu_data1_o/alu_data2_o/ex_store_data_o reflect stored 0 unless forwarding matches. Stored addresses are 0, so they cannot match: outputs are 0.
- Latency: id_* captured on edge N appear on EX outputs after edge N, for the whole of cycle N+1.
- Forwarding muxes and load_use_o are combinational, in the same cycle as their inputs. No combinational path runs from ALU result back into this block.
- A load-use stall costs exactly one bubble.
  - The consumer stays in ID, held by IF/ID via load_use_o, and captures one cycle later.
  - The result then comes via MEM/WB forwarding.
- Reset or flush mid-stall: reset/flush wins; the slot becomes a bubble on that edge.

## Test plan
- Reset: assert rst_i one cycle with id_* random -> all outputs 0, load_use_o=0.
- Back-to-back forward:
  - Setup: EX/MEM matches (rd=5, data=0x11), MEM/WB matches (rd=5, data=0x22), stored rs=5, rs data 0x33.
  - Expect alu_data1_o=0x11. Drop exmem_reg_write_i -> 0x22. Drop memwb_reg_write_i -> 0x33.
- Register 0: EX/MEM rd=0 data=0xDEAD, stored rt=0, rt data 0, alu_src=0 -> alu_data2_o=0.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, rt forward hit with data 0x7 -> alu_data2_o=0xFFFFFFFC, ex_store_data_o=0x7.
- Load-use:
  - Load (mem_read=1, rt=8, reg_dst=0) in EX, ID instruction rs=8 -> load_use_o=1.
  - Next edge: ex_valid_o=0 and all control 0.
  - Following edge: consumer captured, and with MEM/WB rd=8 data=0x99 -> alu_data1_o=0x99.
- Priority:
  - stall_i=1 with load_use_o=1 -> state held unchanged.
  - flush_i=1 with stall_i=1 -> bubble loaded.
  - rst_i=1 with flush_i=0 and a valid ID instruction -> bubble.
